// File: rtl/sc_lane_scheduler_pkg.sv
// Shared types and constants for the lane scheduler: FSM states, lane speed codes
// and the per-level speed table.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package sc_lane_scheduler_pkg;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_LOAD     = 2'd1,
        S_WAIT_ACK = 2'd2,
        S_RUN      = 2'd3
    } state_t;

    localparam logic [1:0] SPD_STOP   = 2'd0;
    localparam logic [1:0] SPD_SLOW   = 2'd1;
    localparam logic [1:0] SPD_NORMAL = 2'd2;
    localparam logic [1:0] SPD_FAST   = 2'd3;

    // Indexed [level][lane]. Level 0 is the parked level: every lane stopped.
    localparam logic [1:0] SPEED_TABLE [4][8] = '{
        '{SPD_STOP,   SPD_STOP,   SPD_STOP,   SPD_STOP,
          SPD_STOP,   SPD_STOP,   SPD_STOP,   SPD_STOP},
        '{SPD_SLOW,   SPD_SLOW,   SPD_SLOW,   SPD_SLOW,
          SPD_SLOW,   SPD_SLOW,   SPD_SLOW,   SPD_SLOW},
        '{SPD_FAST,   SPD_NORMAL, SPD_SLOW,   SPD_STOP,
          SPD_FAST,   SPD_NORMAL, SPD_SLOW,   SPD_STOP},
        '{SPD_NORMAL, SPD_NORMAL, SPD_NORMAL, SPD_NORMAL,
          SPD_NORMAL, SPD_NORMAL, SPD_NORMAL, SPD_NORMAL}
    };

endpackage

// File: rtl/sc_lane_scheduler_if.sv
// Handshake/bus bundle between the level FSM (master) and the lane scheduler (slave).
// Latency: none (wiring only).
// Backpressure: LOAD_OUT is held until the matching LOADED_IN bit is seen.
// Signals: NVL_IN level, CN_IN change strobe, PAUSE_IN freeze, LOADED_IN acks,
//          LOAD_OUT requests, SHIFT_OUT enables, LEVEL_OUT level, BUSY_OUT not-running.
interface sc_lane_scheduler_if #(
    parameter int NLANES = 4
);
    logic [1:0]        SC_LANESCHED_NVL_IN;
    logic              SC_LANESCHED_CN_IN;
    logic              SC_LANESCHED_PAUSE_IN;
    logic [NLANES-1:0] SC_LANESCHED_LOADED_IN;
    logic [NLANES-1:0] SC_LANESCHED_LOAD_OUT;
    logic [NLANES-1:0] SC_LANESCHED_SHIFT_OUT;
    logic [1:0]        SC_LANESCHED_LEVEL_OUT;
    logic              SC_LANESCHED_BUSY_OUT;

    modport master (
        output SC_LANESCHED_NVL_IN, SC_LANESCHED_CN_IN, SC_LANESCHED_PAUSE_IN,
               SC_LANESCHED_LOADED_IN,
        input  SC_LANESCHED_LOAD_OUT, SC_LANESCHED_SHIFT_OUT, SC_LANESCHED_LEVEL_OUT,
               SC_LANESCHED_BUSY_OUT
    );

    modport slave (
        input  SC_LANESCHED_NVL_IN, SC_LANESCHED_CN_IN, SC_LANESCHED_PAUSE_IN,
               SC_LANESCHED_LOADED_IN,
        output SC_LANESCHED_LOAD_OUT, SC_LANESCHED_SHIFT_OUT, SC_LANESCHED_LEVEL_OUT,
               SC_LANESCHED_BUSY_OUT
    );
endinterface

// File: rtl/sc_lane_scheduler_lane_divider.sv
// Per-lane shift divider: counts base ticks and emits a one-clock shift every DIV ticks.
// Latency: shift_o registered on the same edge that samples the terminal tick.
// Backpressure: freeze_i holds the count; speed code STOP holds the count.
// Ports: core_clk/arst_n, tick_i base tick, speed_i code, init_i reload, freeze_i, shift_o.
// Build option: SC_LANESCHED_STAGGER_EN offsets the initial count by lane index.
module sc_lane_divider
    import sc_lane_scheduler_pkg::*;
#(
    parameter int LANE       = 0,
    parameter int DIV_SLOW   = 16,
    parameter int DIV_NORMAL = 8,
    parameter int DIV_FAST   = 4
) (
    input  logic       core_clk,
    input  logic       arst_n,
    input  logic       tick_i,
    input  logic [1:0] speed_i,
    input  logic       init_i,
    input  logic       freeze_i,
    output logic       shift_o
);
    localparam int DMAX = (DIV_SLOW > DIV_NORMAL) ?
                          ((DIV_SLOW > DIV_FAST) ? DIV_SLOW : DIV_FAST) :
                          ((DIV_NORMAL > DIV_FAST) ? DIV_NORMAL : DIV_FAST);
    localparam int CW   = (DMAX <= 2) ? 1 : $clog2(DMAX);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          shift_q, shift_d;
    logic [CW-1:0] reload;
    logic [CW-1:0] init_val;

    always_comb begin
        reload = '0;
        case (speed_i)
            SPD_SLOW:   reload = CW'(DIV_SLOW - 1);
            SPD_NORMAL: reload = CW'(DIV_NORMAL - 1);
            SPD_FAST:   reload = CW'(DIV_FAST - 1);
            default:    reload = '0;
        endcase
    end

`ifdef SC_LANESCHED_STAGGER_EN
    // Lane i fires on base tick i+1 first, spreading equal-speed lanes apart.
    assign init_val = (LANE < int'(reload)) ? CW'(LANE) : reload;
`else
    assign init_val = reload;
`endif

    always_comb begin
        cnt_d   = cnt_q;
        shift_d = 1'b0;
        if (init_i) begin
            cnt_d = init_val;
        end else if (tick_i && !freeze_i && speed_i != SPD_STOP) begin
            if (cnt_q == '0) begin
                shift_d = 1'b1;
                cnt_d   = reload;
            end else begin
                cnt_d = cnt_q - 1'b1;
            end
        end
    end

    always_ff @(posedge core_clk or negedge arst_n) begin
        if (!arst_n) begin
            cnt_q   <= '0;
            shift_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
        end
    end

    assign shift_o = shift_q;

endmodule

// File: rtl/sc_lane_scheduler.sv
// Lane scheduler: on a level change loads each lane register in turn, then paces lane shifts.
// Latency: CN -> LOAD_OUT[0] in 2 clocks; last ack -> RUN in 1 clock; first tick PRESCALE_MAX+1 later.
// Backpressure: an unacknowledged LOAD_OUT holds the sequence indefinitely; PAUSE_IN freezes RUN.
// Ports: SC_LANESCHED_CLOCK_50, SC_LANESCHED_RESET (async active-low), bus (slave modport).
// Build option: SC_LANESCHED_STAGGER_EN (see sc_lane_divider).
module sc_lane_scheduler
    import sc_lane_scheduler_pkg::*;
#(
    parameter int          NLANES       = 4,
    parameter logic [23:0] PRESCALE_MAX = 24'd4_999_999,
    parameter int          DIV_SLOW     = 16,
    parameter int          DIV_NORMAL   = 8,
    parameter int          DIV_FAST     = 4
) (
    input  logic               SC_LANESCHED_CLOCK_50,
    input  logic               SC_LANESCHED_RESET,
    sc_lane_scheduler_if.slave bus
);
    localparam int            PW       = (PRESCALE_MAX == 24'd0) ? 1 : $clog2(int'(PRESCALE_MAX) + 1);
    localparam int            IW       = $clog2(NLANES);
    localparam logic [PW-1:0] PRESC_TC = PW'(PRESCALE_MAX);
    localparam logic [IW-1:0] LAST_IDX = IW'(NLANES - 1);

    state_t            state_q;
    logic [IW-1:0]     idx_q;
    logic              pend_q;
    logic [1:0]        pend_lvl_q;
    logic [1:0]        level_q;
    logic [NLANES-1:0] load_q;
    logic              busy_q;
    logic [PW-1:0]     presc_q;
    logic [NLANES-1:0] shift;

    logic       cn, pause, ack, pend_any, tick, run_init;
    logic [1:0] next_lvl;

    assign cn       = bus.SC_LANESCHED_CN_IN;
    assign pause    = bus.SC_LANESCHED_PAUSE_IN;
    assign ack      = bus.SC_LANESCHED_LOADED_IN[idx_q];
    // A strobe arriving this cycle counts as pending, and its level wins over an older one.
    assign pend_any = pend_q | cn;
    assign next_lvl = cn ? bus.SC_LANESCHED_NVL_IN : pend_lvl_q;
    // A level change on the terminal count swallows that tick.
    assign tick     = (state_q == S_RUN) && !pause && !pend_any && (presc_q == PRESC_TC);
    assign run_init = (state_q == S_WAIT_ACK) && ack && !pend_any && (idx_q == LAST_IDX);

    always_ff @(posedge SC_LANESCHED_CLOCK_50 or negedge SC_LANESCHED_RESET) begin
        if (!SC_LANESCHED_RESET) begin
            state_q    <= S_IDLE;
            idx_q      <= '0;
            pend_q     <= 1'b0;
            pend_lvl_q <= 2'd0;
            level_q    <= 2'd0;
            load_q     <= '0;
            busy_q     <= 1'b1;
            presc_q    <= '0;
        end else begin
            if (cn) begin
                pend_q     <= 1'b1;
                pend_lvl_q <= bus.SC_LANESCHED_NVL_IN;
            end
            case (state_q)
                S_IDLE, S_RUN: begin
                    if (pend_any) begin
                        state_q <= S_LOAD;
                        idx_q   <= '0;
                        pend_q  <= 1'b0;
                        level_q <= next_lvl;
                        busy_q  <= 1'b1;
                        presc_q <= '0;
                    end else if (state_q == S_RUN && !pause) begin
                        presc_q <= (presc_q == PRESC_TC) ? '0 : presc_q + 1'b1;
                    end
                end
                S_LOAD: begin
                    load_q        <= '0;
                    load_q[idx_q] <= 1'b1;
                    state_q       <= S_WAIT_ACK;
                end
                S_WAIT_ACK: begin
                    if (ack) begin
                        load_q <= '0;
                        if (pend_any) begin
                            state_q <= S_LOAD;
                            idx_q   <= '0;
                            pend_q  <= 1'b0;
                            level_q <= next_lvl;
                        end else if (idx_q != LAST_IDX) begin
                            state_q <= S_LOAD;
                            idx_q   <= idx_q + 1'b1;
                        end else begin
                            state_q <= S_RUN;
                            busy_q  <= 1'b0;
                            presc_q <= '0;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    for (genvar i = 0; i < NLANES; i++) begin : g_lane
        sc_lane_divider #(
            .LANE       (i),
            .DIV_SLOW   (DIV_SLOW),
            .DIV_NORMAL (DIV_NORMAL),
            .DIV_FAST   (DIV_FAST)
        ) u_div (
            .core_clk (SC_LANESCHED_CLOCK_50),
            .arst_n   (SC_LANESCHED_RESET),
            .tick_i   (tick),
            .speed_i  (SPEED_TABLE[level_q][i]),
            .init_i   (run_init),
            .freeze_i (pause),
            .shift_o  (shift[i])
        );
    end

    assign bus.SC_LANESCHED_LOAD_OUT  = load_q;
    assign bus.SC_LANESCHED_SHIFT_OUT = shift;
    assign bus.SC_LANESCHED_LEVEL_OUT = level_q;
    assign bus.SC_LANESCHED_BUSY_OUT  = busy_q;

endmodule

// File: tb/tb_sc_lane_scheduler.sv
// Bench for sc_lane_scheduler: directed load sequences with randomized ack delays, pauses
// and level changes, shift pulses predicted from tick arithmetic.
// Clock period 10; inputs driven and outputs sampled on the falling edge.
module tb_sc_lane_scheduler;
    localparam int NL = 4;
    localparam int P  = 3;

    logic clk;
    logic rst_n;

    sc_lane_scheduler_if #(.NLANES(NL)) bus ();

    sc_lane_scheduler #(
        .NLANES       (NL),
        .PRESCALE_MAX (24'd3),
        .DIV_SLOW     (16),
        .DIV_NORMAL   (8),
        .DIV_FAST     (4)
    ) dut (
        .SC_LANESCHED_CLOCK_50 (clk),
        .SC_LANESCHED_RESET    (rst_n),
        .bus                   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         n_cmp = 0;
    int         n_bad = 0;
    int         act   = 0;
    logic [1:0] cur_lvl = 2'd0;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic [NL-1:0] oh(input int i);
        logic [NL-1:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    // Intended speed plan: level 0 parked, 1 all slow, 2 fast/normal/slow/stop, 3 all normal.
    function automatic int code_of(input int lvl, input int lane);
        case (lvl)
            1:       return 1;
            2:       return 3 - (lane % 4);
            3:       return 2;
            default: return 0;
        endcase
    endfunction

    function automatic int div_of(input int code);
        case (code)
            1:       return 16;
            2:       return 8;
            default: return 4;
        endcase
    endfunction

    // Base tick number on which a lane shifts for the first time after RUN entry.
    function automatic int first_tick(input int lane, input int d);
`ifdef SC_LANESCHED_STAGGER_EN
        return ((lane < d - 1) ? lane : d - 1) + 1;
`else
        return d + 0 * lane;
`endif
    endfunction

    task automatic drive_cn(input logic [1:0] lvl);
        bus.SC_LANESCHED_CN_IN  = 1'b1;
        bus.SC_LANESCHED_NVL_IN = lvl;
        step();
        bus.SC_LANESCHED_CN_IN  = 1'b0;
        bus.SC_LANESCHED_NVL_IN = 2'($urandom);
    endtask

    // Entry: LOAD_OUT[i] just became visible. Holds for d-1 clocks, acks on the d-th.
    task automatic ack_lane(input int i, input int d, input bit cn_mid, input logic [1:0] lvl2);
        logic [NL-1:0] noise;
        for (int j = 1; j < d; j++) begin
            noise = NL'($urandom) & ~oh(i);
            bus.SC_LANESCHED_LOADED_IN = noise;
            if (cn_mid && j == 1) begin
                bus.SC_LANESCHED_CN_IN  = 1'b1;
                bus.SC_LANESCHED_NVL_IN = lvl2;
            end
            step();
            bus.SC_LANESCHED_CN_IN = 1'b0;
            chk($sformatf("load_hold_l%0d", i), 32'(bus.SC_LANESCHED_LOAD_OUT), 32'(oh(i)));
        end
        bus.SC_LANESCHED_LOADED_IN = oh(i) | (NL'($urandom) & ~oh(i));
        step();
        bus.SC_LANESCHED_LOADED_IN = '0;
        chk($sformatf("load_drop_l%0d", i), 32'(bus.SC_LANESCHED_LOAD_OUT), 32'(0));
    endtask

    task automatic load_seq(input logic [1:0] lvl, input int cn_lane, input logic [1:0] lvl2,
                            input int dlo, input int dhi);
        int i;
        int d;
        bit restarted;
        bit mid;
        logic [1:0] cur;
        bus.SC_LANESCHED_PAUSE_IN = 1'b0;
        drive_cn(lvl);
        chk("cn_shift_zero", 32'(bus.SC_LANESCHED_SHIFT_OUT), 32'(0));
        chk("cn_busy", 32'(bus.SC_LANESCHED_BUSY_OUT), 32'(1));
        chk("cn_level", 32'(bus.SC_LANESCHED_LEVEL_OUT), 32'(lvl));
        chk("cn_load_idle", 32'(bus.SC_LANESCHED_LOAD_OUT), 32'(0));
        step();
        chk("load_first", 32'(bus.SC_LANESCHED_LOAD_OUT), 32'(oh(0)));
        cur       = lvl;
        i         = 0;
        restarted = 1'b0;
        while (i < NL) begin
            mid = (i == cn_lane) && !restarted;
            d   = $urandom_range(dhi, dlo);
            if (mid && d < 2) d = 2;
            ack_lane(i, d, mid, lvl2);
            if (mid) begin
                restarted = 1'b1;
                cur       = lvl2;
                i         = 0;
                chk("restart_level", 32'(bus.SC_LANESCHED_LEVEL_OUT), 32'(lvl2));
                chk("restart_busy", 32'(bus.SC_LANESCHED_BUSY_OUT), 32'(1));
            end else begin
                i++;
            end
            if (i < NL) begin
                step();
                chk($sformatf("load_next_l%0d", i), 32'(bus.SC_LANESCHED_LOAD_OUT), 32'(oh(i)));
            end
        end
        chk("run_busy", 32'(bus.SC_LANESCHED_BUSY_OUT), 32'(0));
        chk("run_level", 32'(bus.SC_LANESCHED_LEVEL_OUT), 32'(cur));
        cur_lvl = cur;
        act     = 0;
    endtask

    // pmode: 0 no pause, 1 random pause, 2 pause held. align leaves the next edge on a tick.
    task automatic run_check(input int ncyc, input int pmode, input bit align);
        int n;
        int k;
        int c;
        int d;
        int f;
        bit p;
        logic [NL-1:0] exp;
        n = 0;
        while (n < ncyc || (align && (act % (P + 1)) != P)) begin
            if (n >= ncyc)      p = 1'b0;
            else if (pmode == 2) p = 1'b1;
            else if (pmode == 1) p = ($urandom_range(99, 0) < 20);
            else                 p = 1'b0;
            bus.SC_LANESCHED_PAUSE_IN = p;
            step();
            exp = '0;
            if (!p) begin
                act++;
                if ((act % (P + 1)) == 0) begin
                    k = act / (P + 1);
                    for (int l = 0; l < NL; l++) begin
                        c = code_of(int'(cur_lvl), l);
                        if (c != 0) begin
                            d = div_of(c);
                            f = first_tick(l, d);
                            if (k >= f && ((k - f) % d) == 0) exp[l] = 1'b1;
                        end
                    end
                end
            end
            chk("shift", 32'(bus.SC_LANESCHED_SHIFT_OUT), 32'(exp));
            n++;
        end
        bus.SC_LANESCHED_PAUSE_IN = 1'b0;
    endtask

    initial begin
        rst_n                      = 1'b0;
        bus.SC_LANESCHED_NVL_IN    = 2'd0;
        bus.SC_LANESCHED_CN_IN     = 1'b0;
        bus.SC_LANESCHED_PAUSE_IN  = 1'b0;
        bus.SC_LANESCHED_LOADED_IN = '0;
        repeat (3) step();
        chk("rst_load", 32'(bus.SC_LANESCHED_LOAD_OUT), 32'(0));
        chk("rst_shift", 32'(bus.SC_LANESCHED_SHIFT_OUT), 32'(0));
        chk("rst_level", 32'(bus.SC_LANESCHED_LEVEL_OUT), 32'(0));
        chk("rst_busy", 32'(bus.SC_LANESCHED_BUSY_OUT), 32'(1));
        rst_n = 1'b1;
        repeat (5) step();
        chk("idle_load", 32'(bus.SC_LANESCHED_LOAD_OUT), 32'(0));
        chk("idle_busy", 32'(bus.SC_LANESCHED_BUSY_OUT), 32'(1));

        // Level 2 with every lane acked 3 clocks after its request, then free running.
        load_seq(2'd2, -1, 2'd0, 3, 3);
        run_check(300, 0, 1'b0);
        // Long freeze, then resume from the frozen phase; end lined up on a tick.
        run_check(100, 2, 1'b0);
        run_check(200, 0, 1'b1);

        // Change to level 3 on a tick, with a second change to level 1 while lane 1 waits.
        load_seq(2'd3, 1, 2'd1, 1, 5);
        run_check(300, 1, 1'b1);

        // All lanes at equal speed.
        load_seq(2'd3, -1, 2'd0, 1, 4);
        run_check(200, 0, 1'b1);

        for (int r = 0; r < 4; r++) begin
            load_seq(2'($urandom), $urandom_range(4, 0) - 1, 2'($urandom), 1, 5);
            run_check($urandom_range(250, 100), 1, 1'b1);
        end

        // Reset while lane 2 is being loaded.
        drive_cn(2'd2);
        step();
        chk("rs_load0", 32'(bus.SC_LANESCHED_LOAD_OUT), 32'(oh(0)));
        ack_lane(0, 2, 1'b0, 2'd0);
        step();
        ack_lane(1, 2, 1'b0, 2'd0);
        step();
        chk("rs_load2", 32'(bus.SC_LANESCHED_LOAD_OUT), 32'(oh(2)));
        #2 rst_n = 1'b0;
        #1;
        chk("rs_async_load", 32'(bus.SC_LANESCHED_LOAD_OUT), 32'(0));
        chk("rs_async_busy", 32'(bus.SC_LANESCHED_BUSY_OUT), 32'(1));
        chk("rs_async_level", 32'(bus.SC_LANESCHED_LEVEL_OUT), 32'(0));
        @(negedge clk);
        step();
        rst_n = 1'b1;
        for (int j = 0; j < 100; j++) begin
            step();
            chk("rs_idle_shift", 32'(bus.SC_LANESCHED_SHIFT_OUT), 32'(0));
        end
        chk("rs_idle_load", 32'(bus.SC_LANESCHED_LOAD_OUT), 32'(0));
        chk("rs_idle_busy", 32'(bus.SC_LANESCHED_BUSY_OUT), 32'(1));
        load_seq(2'd2, -1, 2'd0, 1, 3);
        run_check(200, 1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
